// File: rtl/kamikaze_mem_writeback.sv
// Memory/writeback stage: owns the integer register file, runs word
// loads/stores on the data bus and provides two bypassed read ports.
module kamikaze_mem_writeback #(
   parameter int BUS_TIMEOUT = 16,
   parameter int TMO_W       = 5
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        ex_valid_i,
   output logic        ex_ready_o,
   input  logic [31:0] ex_result_i,
   input  logic [4:0]  ex_rd_i,
   input  logic        ex_rd_we_i,
   input  logic [1:0]  ex_mem_op_i,
   input  logic [31:0] ex_store_data_i,
   output logic        dbus_req_o,
   output logic        dbus_we_o,
   output logic [31:0] dbus_addr_o,
   output logic [31:0] dbus_wdata_o,
   input  logic        dbus_ack_i,
   input  logic [31:0] dbus_rdata_i,
   input  logic [4:0]  rs1_addr_i,
   output logic [31:0] rs1_data_o,
   input  logic [4:0]  rs2_addr_i,
   output logic [31:0] rs2_data_o,
   output logic        wb_valid_o,
   output logic [4:0]  wb_rd_o,
   output logic [31:0] wb_data_o,
   output logic        misalign_o,
   output logic        bus_err_o
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   logic [0:0]        state_q, state_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [4:0]        rd_q, rd_d;
   logic              rdwe_q, rdwe_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [31:0][31:0] rf_q;
   logic              wb_valid_q, misalign_q, bus_err_q;
   logic [4:0]        wb_rd_q;
   logic [31:0]       wb_data_q;

   logic              wr_en;
   logic [4:0]        wr_rd;
   logic [31:0]       wr_data;
   logic              mis_d;
   logic              abort;
   logic              is_mem;

   assign is_mem = (ex_mem_op_i == 2'b01) || (ex_mem_op_i == 2'b10);

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      rdwe_d  = rdwe_q;
      tmo_d   = tmo_q;
      wr_en   = 1'b0;
      wr_rd   = ex_rd_i;
      wr_data = ex_result_i;
      mis_d   = 1'b0;
      abort   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (ex_valid_i) begin
               if (is_mem) begin
                  if (ex_result_i[1:0] != 2'b00) begin
                     mis_d = 1'b1;
                  end else begin
                     state_d = S_WAIT;
                     req_d   = 1'b1;
                     we_d    = ex_mem_op_i[1];
                     addr_d  = ex_result_i;
                     wdata_d = ex_store_data_i;
                     rd_d    = ex_rd_i;
                     rdwe_d  = ex_rd_we_i;
                     tmo_d   = '0;
                  end
               end else if (ex_rd_we_i && ex_rd_i != 5'd0) begin
                  wr_en = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (dbus_ack_i) begin
               state_d = S_IDLE;
               req_d   = 1'b0;
               tmo_d   = '0;
               if (!we_q && rdwe_q && rd_q != 5'd0) begin
                  wr_en   = 1'b1;
                  wr_rd   = rd_q;
                  wr_data = dbus_rdata_i;
               end
            end else if (tmo_q == TMO_W'(BUS_TIMEOUT - 1)) begin
               // Final allowed request cycle expired without an ack
               abort   = 1'b1;
               state_d = S_IDLE;
               req_d   = 1'b0;
               tmo_d   = '0;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= S_IDLE;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_q       <= '0;
         rdwe_q     <= 1'b0;
         tmo_q      <= '0;
         rf_q       <= '0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rd_q       <= rd_d;
         rdwe_q     <= rdwe_d;
         tmo_q      <= tmo_d;
         wb_valid_q <= wr_en;
         misalign_q <= mis_d;
         bus_err_q  <= abort;
         if (wr_en) begin
            rf_q[wr_rd] <= wr_data;
            wb_rd_q     <= wr_rd;
            wb_data_q   <= wr_data;
         end
      end
   end

   always_comb begin
      rs1_data_o = rf_q[rs1_addr_i];
      rs2_data_o = rf_q[rs2_addr_i];
      if (wr_en && wr_rd == rs1_addr_i) rs1_data_o = wr_data;
      if (wr_en && wr_rd == rs2_addr_i) rs2_data_o = wr_data;
      if (rs1_addr_i == 5'd0) rs1_data_o = '0;
      if (rs2_addr_i == 5'd0) rs2_data_o = '0;
   end

   assign ex_ready_o   = (state_q == S_IDLE);
   assign dbus_req_o   = req_q;
   assign dbus_we_o    = we_q;
   assign dbus_addr_o  = addr_q;
   assign dbus_wdata_o = wdata_q;
   assign wb_valid_o   = wb_valid_q;
   assign wb_rd_o      = wb_rd_q;
   assign wb_data_o    = wb_data_q;
   assign misalign_o   = misalign_q;
   assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_kamikaze_mem_writeback.sv
// Bench for kamikaze_mem_writeback: directed scenarios plus a randomized
// instruction stream checked against an array model of the register file.
module tb_kamikaze_mem_writeback;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        ex_valid_i = 1'b0;
   logic        ex_ready_o;
   logic [31:0] ex_result_i = '0;
   logic [4:0]  ex_rd_i = '0;
   logic        ex_rd_we_i = 1'b0;
   logic [1:0]  ex_mem_op_i = '0;
   logic [31:0] ex_store_data_i = '0;
   logic        dbus_req_o;
   logic        dbus_we_o;
   logic [31:0] dbus_addr_o;
   logic [31:0] dbus_wdata_o;
   logic        dbus_ack_i = 1'b0;
   logic [31:0] dbus_rdata_i = '0;
   logic [4:0]  rs1_addr_i = '0;
   logic [31:0] rs1_data_o;
   logic [4:0]  rs2_addr_i = '0;
   logic [31:0] rs2_data_o;
   logic        wb_valid_o;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_data_o;
   logic        misalign_o;
   logic        bus_err_o;

   int passed = 0;
   int total  = 0;
   logic [31:0] ref_rf [32];

   kamikaze_mem_writeback dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
      .ex_result_i(ex_result_i), .ex_rd_i(ex_rd_i),
      .ex_rd_we_i(ex_rd_we_i), .ex_mem_op_i(ex_mem_op_i),
      .ex_store_data_i(ex_store_data_i),
      .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o),
      .dbus_addr_o(dbus_addr_o), .dbus_wdata_o(dbus_wdata_o),
      .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i),
      .rs1_addr_i(rs1_addr_i), .rs1_data_o(rs1_data_o),
      .rs2_addr_i(rs2_addr_i), .rs2_data_o(rs2_data_o),
      .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
      .misalign_o(misalign_o), .bus_err_o(bus_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_ex(input logic [1:0] op, input logic [31:0] res,
                         input logic [4:0] rd, input logic we,
                         input logic [31:0] sd);
      ex_valid_i      = 1'b1;
      ex_mem_op_i     = op;
      ex_result_i     = res;
      ex_rd_i         = rd;
      ex_rd_we_i      = we;
      ex_store_data_i = sd;
   endtask

   task automatic clr_ex();
      ex_valid_i  = 1'b0;
      ex_mem_op_i = 2'b00;
   endtask

   task automatic test_reset();
      int errs;
      rst_i = 1'b0;
      #1;
      total++; if (ex_ready_o !== 1'b1) $display("FAIL reset_ready got %0b want 1", ex_ready_o); else passed++;
      total++; if ({dbus_req_o, dbus_we_o, wb_valid_o, misalign_o, bus_err_o} !== 5'b0)
         $display("FAIL reset_flags got %b want 00000", {dbus_req_o, dbus_we_o, wb_valid_o, misalign_o, bus_err_o}); else passed++;
      total++; if ({dbus_addr_o, dbus_wdata_o, wb_data_o, wb_rd_o} !== '0)
         $display("FAIL reset_data got %h %h %h %h want 0", dbus_addr_o, dbus_wdata_o, wb_data_o, wb_rd_o); else passed++;
      tick(); tick();
      rst_i = 1'b1;
      for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;
      errs = 0;
      for (int i = 0; i < 32; i++) begin
         rs1_addr_i = 5'(i);
         #1;
         if (rs1_data_o !== 32'h0) errs++;
      end
      total++; if (errs != 0) $display("FAIL reset_regs got %0d nonzero want 0", errs); else passed++;
   endtask

   task automatic test_alu();
      set_ex(2'b00, 32'h12345678, 5'd5, 1'b1, 32'h0);
      rs1_addr_i = 5'd5;
      #1;
      total++; if (rs1_data_o !== 32'h12345678) $display("FAIL alu_bypass got %h want 12345678", rs1_data_o); else passed++;
      tick();
      clr_ex();
      ref_rf[5] = 32'h12345678;
      total++; if ({wb_valid_o, wb_rd_o, wb_data_o} !== {1'b1, 5'd5, 32'h12345678})
         $display("FAIL alu_wb got %b/%0d/%h want 1/5/12345678", wb_valid_o, wb_rd_o, wb_data_o); else passed++;
      #1;
      total++; if (rs1_data_o !== 32'h12345678) $display("FAIL alu_stored got %h want 12345678", rs1_data_o); else passed++;
      tick();
      total++; if (wb_valid_o !== 1'b0) $display("FAIL alu_pulse got %b want 0", wb_valid_o); else passed++;
   endtask

   task automatic test_x0();
      set_ex(2'b00, 32'hFFFFFFFF, 5'd0, 1'b1, 32'h0);
      rs1_addr_i = 5'd0;
      #1;
      total++; if (rs1_data_o !== 32'h0) $display("FAIL x0_bypass got %h want 0", rs1_data_o); else passed++;
      tick();
      clr_ex();
      total++; if (wb_valid_o !== 1'b0) $display("FAIL x0_wb got %b want 0", wb_valid_o); else passed++;
      total++; if (rs1_data_o !== 32'h0) $display("FAIL x0_read got %h want 0", rs1_data_o); else passed++;
   endtask

   task automatic test_load();
      set_ex(2'b01, 32'h100, 5'd7, 1'b1, 32'h0);
      tick();
      clr_ex();
      rs2_addr_i = 5'd7;
      for (int c = 1; c <= 3; c++) begin
         total++; if ({dbus_req_o, ex_ready_o, dbus_we_o, dbus_addr_o} !== {1'b1, 1'b0, 1'b0, 32'h100})
            $display("FAIL load_req c%0d got req=%b rdy=%b we=%b a=%h want 1 0 0 100", c, dbus_req_o, ex_ready_o, dbus_we_o, dbus_addr_o); else passed++;
         if (c == 3) begin
            dbus_ack_i = 1'b1;
            dbus_rdata_i = 32'hCAFEF00D;
            #1;
            total++; if (rs2_data_o !== 32'hCAFEF00D) $display("FAIL load_bypass got %h want cafef00d", rs2_data_o); else passed++;
         end
         tick();
      end
      dbus_ack_i = 1'b0;
      ref_rf[7] = 32'hCAFEF00D;
      total++; if ({dbus_req_o, ex_ready_o} !== 2'b01) $display("FAIL load_done got req=%b rdy=%b want 0 1", dbus_req_o, ex_ready_o); else passed++;
      total++; if ({wb_valid_o, wb_rd_o, wb_data_o} !== {1'b1, 5'd7, 32'hCAFEF00D})
         $display("FAIL load_wb got %b/%0d/%h want 1/7/cafef00d", wb_valid_o, wb_rd_o, wb_data_o); else passed++;
      total++; if (rs2_data_o !== 32'hCAFEF00D) $display("FAIL load_reg got %h want cafef00d", rs2_data_o); else passed++;
   endtask

   task automatic test_store();
      set_ex(2'b10, 32'h204, 5'd9, 1'b1, 32'hA5A5A5A5);
      tick();
      clr_ex();
      ex_store_data_i = 32'h0;
      ex_result_i = 32'h0;
      for (int c = 1; c <= 2; c++) begin
         total++; if ({dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wdata_o} !== {2'b11, 32'h204, 32'hA5A5A5A5})
            $display("FAIL store_bus c%0d got %b%b %h %h want 11 204 a5a5a5a5", c, dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wdata_o); else passed++;
         if (c == 2) dbus_ack_i = 1'b1;
         tick();
      end
      dbus_ack_i = 1'b0;
      rs1_addr_i = 5'd9;
      #1;
      total++; if (wb_valid_o !== 1'b0) $display("FAIL store_wb got %b want 0", wb_valid_o); else passed++;
      total++; if (rs1_data_o !== ref_rf[9]) $display("FAIL store_rd got %h want %h", rs1_data_o, ref_rf[9]); else passed++;
   endtask

   task automatic test_misalign();
      set_ex(2'b01, 32'h102, 5'd7, 1'b1, 32'h0);
      tick();
      clr_ex();
      total++; if ({misalign_o, dbus_req_o, ex_ready_o, wb_valid_o} !== 4'b1010)
         $display("FAIL misalign_pulse got mis=%b req=%b rdy=%b wb=%b want 1 0 1 0", misalign_o, dbus_req_o, ex_ready_o, wb_valid_o); else passed++;
      dbus_ack_i = 1'b1;
      tick();
      dbus_ack_i = 1'b0;
      rs1_addr_i = 5'd7;
      #1;
      total++; if ({misalign_o, dbus_req_o, wb_valid_o} !== 3'b000)
         $display("FAIL misalign_after got mis=%b req=%b wb=%b want 0 0 0", misalign_o, dbus_req_o, wb_valid_o); else passed++;
      total++; if (rs1_data_o !== ref_rf[7]) $display("FAIL misalign_rd got %h want %h", rs1_data_o, ref_rf[7]); else passed++;
   endtask

   task automatic test_timeout();
      int low;
      set_ex(2'b01, 32'h300, 5'd10, 1'b1, 32'h0);
      tick();
      clr_ex();
      low = 0;
      for (int c = 1; c <= 16; c++) begin
         if (dbus_req_o !== 1'b1) low++;
         tick();
      end
      total++; if (low != 0) $display("FAIL tmo_held got %0d low cycles want 0", low); else passed++;
      total++; if ({dbus_req_o, bus_err_o, wb_valid_o, ex_ready_o} !== 4'b0101)
         $display("FAIL tmo_abort got req=%b err=%b wb=%b rdy=%b want 0 1 0 1", dbus_req_o, bus_err_o, wb_valid_o, ex_ready_o); else passed++;
      tick();
      rs1_addr_i = 5'd10;
      #1;
      total++; if (bus_err_o !== 1'b0) $display("FAIL tmo_pulse got %b want 0", bus_err_o); else passed++;
      total++; if (rs1_data_o !== ref_rf[10]) $display("FAIL tmo_rd got %h want %h", rs1_data_o, ref_rf[10]); else passed++;
   endtask

   task automatic test_ack_final();
      set_ex(2'b01, 32'h400, 5'd11, 1'b1, 32'h0);
      tick();
      clr_ex();
      for (int c = 1; c <= 16; c++) begin
         if (c == 16) begin
            dbus_ack_i = 1'b1;
            dbus_rdata_i = 32'h0BADBEEF;
         end
         tick();
      end
      dbus_ack_i = 1'b0;
      ref_rf[11] = 32'h0BADBEEF;
      total++; if ({bus_err_o, dbus_req_o, wb_valid_o, wb_rd_o, wb_data_o} !== {3'b001, 5'd11, 32'h0BADBEEF})
         $display("FAIL ack_final got err=%b req=%b wb=%b/%0d/%h want 0 0 1/11/0badbeef", bus_err_o, dbus_req_o, wb_valid_o, wb_rd_o, wb_data_o); else passed++;
   endtask

   task automatic test_back_to_back();
      int kind, lat;
      logic [4:0]  rd, ra;
      logic        we, exp_wb;
      logic [31:0] val, sd, rdat, addr, exp_rd;
      for (int n = 0; n < 80; n++) begin
         kind = $urandom_range(0, 4);
         rd   = 5'($urandom);
         we   = 1'($urandom);
         val  = $urandom;
         sd   = $urandom;
         rdat = $urandom;
         lat  = $urandom_range(1, 4);
         if (kind == 0 || kind == 4) begin
            set_ex(kind == 4 ? 2'b11 : 2'b00, val, rd, we, sd);
            rs1_addr_i = rd;
            exp_wb = we && rd != 5'd0;
            exp_rd = exp_wb ? val : ref_rf[rd];
            #1;
            total++; if (ex_ready_o !== 1'b1) $display("FAIL rnd_ready n%0d got 0 want 1", n); else passed++;
            total++; if (rs1_data_o !== exp_rd) $display("FAIL rnd_bypass n%0d got %h want %h", n, rs1_data_o, exp_rd); else passed++;
            tick();
            clr_ex();
            if (exp_wb) ref_rf[rd] = val;
            total++; if (wb_valid_o !== exp_wb || (exp_wb && {wb_rd_o, wb_data_o} !== {rd, val}))
               $display("FAIL rnd_alu_wb n%0d got %b/%0d/%h want %b/%0d/%h", n, wb_valid_o, wb_rd_o, wb_data_o, exp_wb, rd, val); else passed++;
         end else if (kind == 1 || kind == 2) begin
            addr = {val[31:2], 2'b00};
            set_ex(kind == 1 ? 2'b01 : 2'b10, addr, rd, we, sd);
            tick();
            clr_ex();
            for (int c = 1; c <= lat; c++) begin
               total++; if ({dbus_req_o, dbus_we_o, dbus_addr_o} !== {1'b1, kind == 2, addr} || (kind == 2 && dbus_wdata_o !== sd))
                  $display("FAIL rnd_bus n%0d got %b%b %h %h want 1%0d %h %h", n, dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wdata_o, kind == 2, addr, sd); else passed++;
               if (c == lat) begin
                  dbus_ack_i = 1'b1;
                  dbus_rdata_i = rdat;
               end
               tick();
            end
            dbus_ack_i = 1'b0;
            exp_wb = kind == 1 && we && rd != 5'd0;
            if (exp_wb) ref_rf[rd] = rdat;
            total++; if (wb_valid_o !== exp_wb || dbus_req_o !== 1'b0 || bus_err_o !== 1'b0 || (exp_wb && {wb_rd_o, wb_data_o} !== {rd, rdat}))
               $display("FAIL rnd_mem_wb n%0d got %b/%0d/%h req=%b want %b/%0d/%h", n, wb_valid_o, wb_rd_o, wb_data_o, dbus_req_o, exp_wb, rd, rdat); else passed++;
         end else begin
            addr = {val[31:2], 2'($urandom_range(1, 3))};
            set_ex($urandom_range(0, 1) ? 2'b01 : 2'b10, addr, rd, we, sd);
            tick();
            clr_ex();
            total++; if ({misalign_o, dbus_req_o, wb_valid_o} !== 3'b100)
               $display("FAIL rnd_misalign n%0d got %b%b%b want 100", n, misalign_o, dbus_req_o, wb_valid_o); else passed++;
         end
         ra = 5'($urandom);
         rs2_addr_i = ra;
         #1;
         total++; if (rs2_data_o !== ref_rf[ra]) $display("FAIL rnd_read n%0d x%0d got %h want %h", n, ra, rs2_data_o, ref_rf[ra]); else passed++;
      end
   endtask

   task automatic test_reset_mid();
      int errs;
      set_ex(2'b01, 32'h500, 5'd12, 1'b1, 32'h0);
      tick();
      clr_ex();
      total++; if (dbus_req_o !== 1'b1) $display("FAIL rstmid_req got %b want 1", dbus_req_o); else passed++;
      tick();
      rst_i = 1'b0;
      #1;
      total++; if ({dbus_req_o, ex_ready_o} !== 2'b01) $display("FAIL rstmid_drop got req=%b rdy=%b want 0 1", dbus_req_o, ex_ready_o); else passed++;
      dbus_ack_i = 1'b1;
      dbus_rdata_i = 32'h77777777;
      tick();
      rst_i = 1'b1;
      for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;
      tick();
      dbus_ack_i = 1'b0;
      total++; if ({wb_valid_o, dbus_req_o} !== 2'b00) $display("FAIL rstmid_ack got wb=%b req=%b want 0 0", wb_valid_o, dbus_req_o); else passed++;
      errs = 0;
      for (int i = 0; i < 32; i++) begin
         rs1_addr_i = 5'(i);
         #1;
         if (rs1_data_o !== ref_rf[i]) errs++;
      end
      total++; if (errs != 0) $display("FAIL rstmid_regs got %0d nonzero want 0", errs); else passed++;
   endtask

   initial begin
      test_reset();
      test_alu();
      test_x0();
      test_load();
      test_store();
      test_misalign();
      test_timeout();
      test_ack_final();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
